// File: rtl/vl_dline_var_rd.sv
// Variable-depth delay line: circular buffer with registered read, clamped delay select,
// and a PRIME/RUN sequencer that masks output until d fresh samples are in the buffer.
module vl_dline_var_rd #(
  parameter int   DEPTH   = 16,
  parameter int   AW      = 4,
  parameter int   WIDTH   = 8,
  parameter logic RST_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  input  logic [AW:0]      dly,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             dly_err
);

  typedef enum logic {PRIME, RUN} state_t;

  localparam logic [AW:0] D_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0] D_ONE = (AW+1)'(1);

  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    raddr;
  logic [AW:0]      dly_q;
  logic [AW:0]      d_new;
  logic [AW:0]      d_old;
  logic [AW:0]      cnt_q;
  logic [AW:0]      cnt_d;
  state_t           state_q;
  state_t           state_d;
  logic             restart;
  logic             oor_new;
  logic             unmask;
  logic [WIDTH:0]   rd_word;
  logic [WIDTH-1:0] dout_d;
  logic             dout_vld_d;

  function automatic logic [AW:0] clamp_d(input logic [AW:0] v);
    if (v == '0)
      return D_ONE;
    else if (v > D_MAX)
      return D_MAX;
    else
      return v;
  endfunction

  // The read is taken on edge k+d-1 for data written on edge k, so the entry
  // sits d-1 slots behind the write pointer; d=1 bypasses storage entirely.
  always_comb begin
    d_new   = clamp_d(dly);
    d_old   = clamp_d(dly_q);
    restart = clr || (d_new != d_old);
    oor_new = (dly == '0) || (dly > D_MAX);
    raddr   = wptr - AW'(d_new - D_ONE);
    rd_word = (d_new == D_ONE) ? {din_vld, din} : mem[raddr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PRIME;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (restart) begin
      state_d = PRIME;
      cnt_d   = '0;
    end else if (state_q == PRIME) begin
      cnt_d = cnt_q + D_ONE;
      if (cnt_d == d_new)
        state_d = RUN;
    end
  end

  always_comb begin
    unmask     = (state_d == RUN);
    dout_d     = unmask ? rd_word[WIDTH-1:0] : {WIDTH{RST_VAL}};
    dout_vld_d = unmask && rd_word[WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr     <= '0;
      dly_q    <= '0;
      dout     <= {WIDTH{RST_VAL}};
      dout_vld <= 1'b0;
      busy     <= 1'b1;
      dly_err  <= 1'b0;
    end else begin
      wptr     <= wptr + AW'(1);
      dly_q    <= dly;
      dout     <= dout_d;
      dout_vld <= dout_vld_d;
      busy     <= !unmask;
      dly_err  <= oor_new && (dly != dly_q);
    end
  end

  always_ff @(posedge clk) begin
    mem[wptr] <= {din_vld, din};
  end

endmodule

// File: tb/tb_vl_dline_var_rd.sv
// Directed bench for vl_dline_var_rd: din sampled at edge n equals n-2, so the
// first sample after the post-reset delay event is 0x00 and expectations are edge arithmetic.
module tb_vl_dline_var_rd;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic             din_vld;
    logic [AW:0]      dly;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             busy;
    logic             dly_err;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    vl_dline_var_rd #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .WIDTH  (WIDTH),
        .RST_VAL(1'b0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .din     (din),
        .din_vld (din_vld),
        .dly     (dly),
        .dout    (dout),
        .dout_vld(dout_vld),
        .busy    (busy),
        .dly_err (dly_err)
    );

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    task automatic expect_out(input string tag, input int d, input int v, input int b);
        check({tag, "_dout"}, int'(dout), d);
        check({tag, "_vld"}, int'(dout_vld), v);
        check({tag, "_busy"}, int'(busy), b);
    endtask

    // din_vld drops on edges 91 and 94 to form the 1,0,1,1,0 pattern over 90..94.
    task automatic drive_stream();
        din     = 8'(edge_n + 1 - 2);
        din_vld = !((edge_n + 1) == 91 || (edge_n + 1) == 94);
    endtask

    task automatic step();
        @(posedge clk);
        edge_n++;
        #1;
        drive_stream();
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) step();
    endtask

    logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        reset_n = 1'b0;
        clr     = 1'b0;
        dly     = 5'd5;
        edge_n  = 0;
        drive_stream();
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 0, 0, 1);
        check("reset_err", int'(dly_err), 0);

        @(negedge clk);
        reset_n = 1'b1;
        edge_n  = 0;
        drive_stream();

        for (int n = 1; n <= 5; n++) begin
            step();
            expect_out($sformatf("prime5_e%0d", n), 0, 0, 1);
            check($sformatf("noerr_e%0d", n), int'(dly_err), 0);
        end
        step();
        expect_out("first_valid", 8'h00, 1, 0);
        step();
        expect_out("inc1", 8'h01, 1, 0);
        step();
        expect_out("inc2", 8'h02, 1, 0);

        run_to(19);
        expect_out("pre_clr", 13, 1, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        expect_out("clr_e20", 0, 0, 1);
        for (int n = 21; n <= 24; n++) begin
            step();
            expect_out($sformatf("clr_e%0d", n), 0, 0, 1);
        end
        step();
        expect_out("post_clr", 19, 1, 0);

        step();
        dly = 5'd3;
        step();
        expect_out("dly3_prime", 0, 0, 1);
        run_to(30);
        expect_out("dly3_first", 26, 1, 0);
        step();
        expect_out("dly3_next", 27, 1, 0);

        dly = 5'd16;
        step();
        expect_out("dly16_e32", 0, 0, 1);
        run_to(47);
        expect_out("dly16_e47", 0, 0, 1);
        step();
        expect_out("dly16_first", 31, 1, 0);
        step();
        expect_out("dly16_next", 32, 1, 0);
        run_to(60);
        expect_out("dly16_wrap", 43, 1, 0);

        dly = 5'd0;
        step();
        check("err_dly0", int'(dly_err), 1);
        expect_out("dly0_prime", 0, 0, 1);
        step();
        check("err_dly0_pulse", int'(dly_err), 0);
        expect_out("dly0_first", 60, 1, 0);
        step();
        expect_out("dly0_next", 61, 1, 0);

        dly = 5'd31;
        step();
        check("err_dly31", int'(dly_err), 1);
        expect_out("dly31_prime", 0, 0, 1);
        step();
        check("err_dly31_pulse", int'(dly_err), 0);
        run_to(79);
        expect_out("dly31_e79", 0, 0, 1);
        step();
        expect_out("dly31_first", 63, 1, 0);

        dly = 5'd4;
        step();
        expect_out("dly4_prime", 0, 0, 1);
        run_to(85);
        expect_out("dly4_first", 80, 1, 0);
        run_to(92);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("vld_pat%0d", i), int'(dout_vld), int'(pat[i]));
        end
        step();
        check("vld_pat_end", int'(dout_vld), 1);
        run_to(100);
        expect_out("pre_rst", 95, 1, 0);

        #1;
        reset_n = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 1);
        check("async_rst_err", int'(dly_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        edge_n  = 0;
        drive_stream();
        for (int n = 1; n <= 4; n++) begin
            step();
            expect_out($sformatf("reprime_e%0d", n), 0, 0, 1);
        end
        step();
        expect_out("reprime_first", 8'h00, 1, 0);
        step();
        expect_out("reprime_next", 8'h01, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
